// File: rtl/rob_req_issue.sv
// rtl/rob_req_issue.sv - ROB request issue stage: 2-entry skid buffer, slot tagging, occupancy credit
// Optional memory-stall watchdog enabled by defining ROB_ISSUE_TIMEOUT_EN.
module rob_req_issue #(
  parameter int ROB_SIZE = 128,
  parameter int AWIDTH   = 4,
  parameter int SWIDTH   = 4,
  parameter int TAGW     = $clog2(ROB_SIZE),
  parameter int TIMEOUT  = 200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [SWIDTH-1:0] req_id,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [TAGW-1:0]   mem_tag,
  output logic              rob_alloc_valid,
  output logic [TAGW-1:0]   rob_alloc_tag,
  output logic [SWIDTH-1:0] rob_alloc_id,
  input  logic              retire_valid,
  output logic [TAGW:0]     occupancy,
  output logic              rob_full,
  output logic              underflow_err,
  output logic              timeout_err
);

  localparam logic [TAGW:0] FULL_OCC = (TAGW+1)'(ROB_SIZE);

  logic [AWIDTH-1:0] buf_addr [2];
  logic [SWIDTH-1:0] buf_id   [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic [TAGW-1:0]   alloc_ptr;
  logic              push;
  logic              xfer;
  logic [TAGW:0]     occ_next;
  logic              underflow_set;

  assign req_ready = (count != 2'd2);
  assign push      = req_valid && req_ready;
  assign xfer      = (count != 2'd0) && (occupancy < FULL_OCC) && (!mem_valid || mem_ready);

  // A retire at zero occupancy is only an error when no allocation lands in the same cycle.
  always_comb begin
    occ_next      = occupancy;
    underflow_set = 1'b0;
    case ({xfer, retire_valid})
      2'b10:   occ_next = occupancy + 1'b1;
      2'b01: begin
        if (occupancy == '0) underflow_set = 1'b1;
        else                 occ_next = occupancy - 1'b1;
      end
      default: occ_next = occupancy;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr[wr_ptr] <= req_addr;
      buf_id[wr_ptr]   <= req_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr          <= 1'b0;
      rd_ptr          <= 1'b0;
      count           <= 2'd0;
      alloc_ptr       <= '0;
      mem_valid       <= 1'b0;
      mem_addr        <= '0;
      mem_tag         <= '0;
      rob_alloc_valid <= 1'b0;
      rob_alloc_tag   <= '0;
      rob_alloc_id    <= '0;
      occupancy       <= '0;
      rob_full        <= 1'b0;
      underflow_err   <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (xfer) rd_ptr <= ~rd_ptr;
      count     <= count + {1'b0, push} - {1'b0, xfer};
      occupancy <= occ_next;
      rob_full  <= (occ_next == FULL_OCC);
      if (underflow_set) underflow_err <= 1'b1;
      if (xfer) begin
        mem_valid       <= 1'b1;
        mem_addr        <= buf_addr[rd_ptr];
        mem_tag         <= alloc_ptr;
        rob_alloc_valid <= 1'b1;
        rob_alloc_tag   <= alloc_ptr;
        rob_alloc_id    <= buf_id[rd_ptr];
        alloc_ptr       <= alloc_ptr + 1'b1;
      end else begin
        rob_alloc_valid <= 1'b0;
        if (mem_valid && mem_ready) mem_valid <= 1'b0;
      end
    end
  end

`ifdef ROB_ISSUE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] stall_cnt;

  // Counter saturates at TIMEOUT so a very long stall cannot wrap it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else if (mem_valid && !mem_ready) begin
      if (stall_cnt != CW'(TIMEOUT))     stall_cnt   <= stall_cnt + 1'b1;
      if (stall_cnt == CW'(TIMEOUT - 1)) timeout_err <= 1'b1;
    end else begin
      stall_cnt <= '0;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/rob_req_issue.md
Name: rob_req_issue

Overview:
Request issue stage directly upstream of the reorder buffer. Accepts in-order requests (addr, source ID) through a valid/ready port and buffers them in a 2-entry skid buffer. Each request is assigned a sequential ROB slot tag, then issued to the memory interface while a matching allocation record goes to the ROB. A slot-occupancy credit counter, decremented by ROB retire pulses, stops issue when all ROB_SIZE slots are in flight.

Parameters:
ROB_SIZE, 128, number of ROB slots; power of two, ≥ 2
AWIDTH, 4, request address width
SWIDTH, 4, source ID width
TAGW, $clog2(ROB_SIZE), slot tag width (7 at default)
TIMEOUT, 200, memory-stall watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  upstream request valid
req_ready  out  1  skid buffer can accept
req_addr  in  AWIDTH  request address
req_id  in  SWIDTH  request source ID
mem_valid  out  1  issued request valid to memory
mem_ready  in  1  memory accepts
mem_addr  out  AWIDTH  issued address
mem_tag  out  TAGW  ROB slot tag travelling with the request
rob_alloc_valid  out  1  one-cycle allocation pulse to the ROB
rob_alloc_tag  out  TAGW  allocated slot
rob_alloc_id  out  SWIDTH  source ID stored in that slot
retire_valid  in  1  ROB freed one slot this cycle (in-order retire)
occupancy  out  TAGW+1  slots in flight, 0..ROB_SIZE
rob_full  out  1  occupancy == ROB_SIZE
underflow_err  out  1  sticky: retire_valid seen with occupancy == 0
timeout_err  out  1  sticky watchdog flag (optional feature)

Behaviour:
- Reset (asynchronous, rst_n low): skid buffer empty, req_ready=1, mem_valid=0, mem_addr/mem_tag=0, rob_alloc_valid=0, rob_alloc_tag/id=0, alloc pointer=0, occupancy=0, rob_full=0, underflow_err=0, timeout_err=0. Reset mid-operation discards all buffered and in-flight state; the first tag after reset is 0.
- Skid buffer: 2-entry FIFO of {addr, id}. req_ready = (count < 2), decoded from registered count. Push on req_valid && req_ready. FIFO order preserved.
- Transfer condition T = buffer non-empty && occupancy < ROB_SIZE && (!mem_valid || mem_ready).
- On T (same edge): head is popped; mem_valid←1; mem_addr←head.addr; mem_tag←alloc_ptr; rob_alloc_valid←1; rob_alloc_tag←alloc_ptr; rob_alloc_id←head.id; alloc_ptr←(alloc_ptr+1) mod ROB_SIZE; occupancy+1.
- Otherwise: rob_alloc_valid←0. If mem_valid && mem_ready, then mem_valid←0. mem_addr/mem_tag hold.
- Latency: a request accepted into an empty buffer at edge N appears on mem_valid/rob_alloc_valid at edge N+1, provided a slot is free.
- mem_* outputs stay stable while mem_valid && !mem_ready (AXI-style hold). Back-to-back issue is possible at one per cycle when mem_ready=1.
- Occupancy: +1 on T, −1 on retire_valid; both in the same cycle → unchanged. retire_valid with occupancy==0 (and no T) is ignored and sets underflow_err. A simultaneous T and retire at 0 is treated as a net 0 with no error.
- rob_full is registered and equals (occupancy == ROB_SIZE). A full ROB blocks T; the buffer then fills and req_ready drops.
- Tag wrap: after tag ROB_SIZE−1 the next tag is 0. The credit limit guarantees a tag is never reused while its slot is still occupied.
- Push and pop in the same cycle with count==2 is impossible (req_ready=0). With count==1, a simultaneous push and pop keeps count at 1.

Optional Feature:
ROB_ISSUE_TIMEOUT_EN: when defined, a counter increments each cycle that mem_valid && !mem_ready and clears on a handshake or when mem_valid=0. When the count reaches TIMEOUT, timeout_err sets and stays set until reset; issue behaviour is unaffected. When not defined, the counter is absent and timeout_err is tied to 0.

Test Plan:
- Reset then one request addr=0x5 id=0x3, mem_ready=1 → next cycle mem_valid=1, mem_addr=0x5, mem_tag=0, rob_alloc_valid pulse with id=0x3, occupancy=1.
- 130 back-to-back requests, mem_ready=1, no retire → tags 0..127 issued, occupancy=128, rob_full=1, 2 requests held in buffer, req_ready=0.
- From the full state, assert one retire_valid → 129th request issued with tag 0 (wrap), occupancy stays 128.
- mem_ready=0 for 5 cycles with mem_valid=1 → mem_addr/mem_tag unchanged, only 2 further requests accepted, then req_ready=0.
- Steady traffic with retire_valid every cycle at occupancy=10 → occupancy remains 10. A retire pulse from reset → underflow_err=1, occupancy=0.
- With ROB_ISSUE_TIMEOUT_EN: hold mem_ready=0 for 200 cycles after mem_valid → timeout_err=1 at count 200, stays set after mem_ready returns.
